// File: rtl/corelet_ctrl.sv
// corelet_ctrl
// ------------
// Memory-side sequencer for one weight-stationary corelet tile.
//
// A tile runs through these phases:
//   1. Fetch col weight words from activation SRAM into L0.
//   2. Replay them out of L0 as kernel-load instructions.
//   3. Wait for the PE array to settle.
//   4. Fetch num_x activation vectors into L0.
//   5. Replay them as execute instructions.
//   6. Drain num_x psum rows from the OFIFO into psum SRAM.
//   7. Pulse done.
//
// Ports:
//   clk, reset            clock; synchronous active-high reset
//   start                 one-cycle tile request, honoured only while idle
//   w_base/x_base/o_base  weight / activation / psum base addresses,
//                         captured when start is accepted
//   busy, done            busy from acceptance until the done cycle;
//                         done is a one-cycle pulse
//   xmem_*                activation SRAM read port (cen active-low,
//                         q valid one cycle after the read)
//   l0_wr/l0_rd/l0_wdata  L0 strobes and write data
//   ififo_*               unused in weight-stationary mode, tied low
//   inst_w                [0] kernel load, [1] execute, [2] always 0
//   ofifo_rd/valid/rdata  OFIFO read port (rdata valid with ofifo_rd)
//   pmem_*                psum SRAM write port (cen/wen active-low)
//   state_dbg             current FSM state, for checkers
//
// Handshake semantics: start is a request that is accepted only in IDLE
// and is otherwise dropped. An OFIFO row transfers in a cycle where both
// ofifo_valid and ofifo_rd are high. No backpressure is applied to the
// SRAMs; they accept every cycle.
//
// Optional feature (macro CORELET_CTRL_PERF_EN): adds perf_cycles, which
// counts tile cycles from acceptance through the done cycle, and
// perf_stall, which counts DRAIN cycles that wait on the OFIFO.
module corelet_ctrl #(
  parameter int bw      = 4,
  parameter int psum_bw = 16,
  parameter int col     = 8,
  parameter int row     = 8,
  parameter int num_x   = 16,
  parameter int addr_bw = 11,
  parameter int settle  = row + col
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [addr_bw-1:0]       w_base,
  input  logic [addr_bw-1:0]       x_base,
  input  logic [addr_bw-1:0]       o_base,
  output logic                     busy,
  output logic                     done,
  output logic                     xmem_cen,
  output logic [addr_bw-1:0]       xmem_addr,
  input  logic [bw*row-1:0]        xmem_q,
  output logic                     l0_wr,
  output logic                     l0_rd,
  output logic [bw*row-1:0]        l0_wdata,
  output logic                     ififo_wr,
  output logic                     ififo_rd,
  output logic [bw*row-1:0]        ififo_wdata,
  output logic [2:0]               inst_w,
  output logic                     ofifo_rd,
  input  logic                     ofifo_valid,
  input  logic [psum_bw*col-1:0]   ofifo_rdata,
  output logic                     pmem_cen,
  output logic                     pmem_wen,
  output logic [addr_bw-1:0]       pmem_addr,
  output logic [psum_bw*col-1:0]   pmem_d,
  output logic [2:0]               state_dbg
`ifdef CORELET_CTRL_PERF_EN
  ,
  output logic [31:0]              perf_cycles,
  output logic [15:0]              perf_stall
`endif
);

  // Phase counter must hold col, settle-1 and num_x.
  localparam int MAX_N  = (col > settle) ? ((col > num_x) ? col : num_x)
                                         : ((settle > num_x) ? settle : num_x);
  localparam int CNT_W  = $clog2(MAX_N + 1);
  localparam int XCNT_W = $clog2(num_x + 1);

  localparam logic [CNT_W-1:0]  COL_N       = CNT_W'(col);
  localparam logic [CNT_W-1:0]  COL_LAST    = CNT_W'(col - 1);
  // A zero settle still spends one cycle in SETTLE.
  localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'((settle > 0) ? settle - 1 : 0);
  localparam logic [CNT_W-1:0]  X_N         = CNT_W'(num_x);
  localparam logic [CNT_W-1:0]  X_LAST      = CNT_W'(num_x - 1);
  localparam logic [XCNT_W-1:0] ROWS_N      = XCNT_W'(num_x);
  localparam logic [XCNT_W-1:0] ROWS_LAST   = XCNT_W'(num_x - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_W_FETCH = 3'd1,
    S_W_LOAD  = 3'd2,
    S_SETTLE  = 3'd3,
    S_X_FETCH = 3'd4,
    S_EXEC    = 3'd5,
    S_DRAIN   = 3'd6,
    S_DONE    = 3'd7
  } state_t;

  state_t                   state, state_next;
  logic [CNT_W-1:0]         cnt;
  logic [addr_bw-1:0]       w_base_r, x_base_r, o_base_r;
  logic [XCNT_W-1:0]        rd_cnt;      // OFIFO rows read this tile
  logic [XCNT_W-1:0]        wr_cnt;      // psum rows written this tile
  logic                     wr_pending;  // a row read last cycle must be written now
  logic [psum_bw*col-1:0]   wr_data;
  logic [addr_bw-1:0]       fetch_base;
  logic [CNT_W-1:0]         fetch_n;

  assign state_dbg   = state;
  assign ififo_wr    = 1'b0;
  assign ififo_rd    = 1'b0;
  assign ififo_wdata = '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      cnt        <= '0;
      w_base_r   <= '0;
      x_base_r   <= '0;
      o_base_r   <= '0;
      rd_cnt     <= '0;
      wr_cnt     <= '0;
      wr_pending <= 1'b0;
      wr_data    <= '0;
    end else begin
      state <= state_next;
      // cnt is the cycle index within the current phase.
      if (state == S_IDLE || state == S_DRAIN || state_next != state)
        cnt <= '0;
      else
        cnt <= cnt + 1'b1;

      if (state == S_IDLE && start) begin
        w_base_r <= w_base;
        x_base_r <= x_base;
        o_base_r <= o_base;
        rd_cnt   <= '0;
        wr_cnt   <= '0;
      end else begin
        if (ofifo_rd)   rd_cnt <= rd_cnt + 1'b1;
        if (wr_pending) wr_cnt <= wr_cnt + 1'b1;
      end

      // The OFIFO row is only valid in its read cycle, so hold it one
      // cycle for the psum write.
      wr_pending <= ofifo_rd;
      if (ofifo_rd) wr_data <= ofifo_rdata;
    end
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    xmem_cen   = 1'b1;
    xmem_addr  = '0;
    l0_wr      = 1'b0;
    l0_rd      = 1'b0;
    l0_wdata   = '0;
    inst_w     = 3'b000;
    ofifo_rd   = 1'b0;
    pmem_cen   = 1'b1;
    pmem_wen   = 1'b1;
    pmem_addr  = '0;
    pmem_d     = '0;
    fetch_base = (state == S_W_FETCH) ? w_base_r : x_base_r;
    fetch_n    = (state == S_W_FETCH) ? COL_N : X_N;

    busy = (state != S_IDLE) && (state != S_DONE);

    unique case (state)
      S_IDLE: begin
        if (start) state_next = S_W_FETCH;
      end

      // Reads in cycles 0..N-1; the SRAM returns each word one cycle
      // later, so L0 writes occupy cycles 1..N.
      S_W_FETCH, S_X_FETCH: begin
        if (cnt < fetch_n) begin
          xmem_cen  = 1'b0;
          xmem_addr = fetch_base + addr_bw'(cnt);
        end
        if (cnt != '0) begin
          l0_wr    = 1'b1;
          l0_wdata = xmem_q;
        end
        if (cnt == fetch_n)
          state_next = (state == S_W_FETCH) ? S_W_LOAD : S_EXEC;
      end

      S_W_LOAD: begin
        l0_rd  = 1'b1;
        inst_w = 3'b001;
        if (cnt == COL_LAST) state_next = S_SETTLE;
      end

      S_SETTLE: begin
        if (cnt == SETTLE_LAST) state_next = S_X_FETCH;
      end

      S_EXEC: begin
        l0_rd  = 1'b1;
        inst_w = 3'b010;
        if (cnt == X_LAST) state_next = S_DRAIN;
      end

      S_DRAIN: begin
        ofifo_rd = ofifo_valid && (rd_cnt < ROWS_N);
        if (wr_pending) begin
          pmem_cen  = 1'b0;
          pmem_wen  = 1'b0;
          pmem_addr = o_base_r + addr_bw'(wr_cnt);
          pmem_d    = wr_data;
          if (wr_cnt == ROWS_LAST) state_next = S_DONE;
        end
      end

      S_DONE: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end

      default: state_next = S_IDLE;
    endcase
  end

`ifdef CORELET_CTRL_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_cycles <= '0;
      perf_stall  <= '0;
    end else if (state == S_IDLE) begin
      if (start) begin
        perf_cycles <= '0;
        perf_stall  <= '0;
      end
    end else begin
      perf_cycles <= perf_cycles + 1'b1;
      if (state == S_DRAIN && !ofifo_valid && rd_cnt < ROWS_N)
        perf_stall <= perf_stall + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_corelet_ctrl.sv
// tb_corelet_ctrl
// ---------------
// Directed-plus-random bench for corelet_ctrl. SRAM and OFIFO behaviour
// comes from small behavioural models. Each tile's expected read
// addresses, L0 data, and psum writes are precomputed from the tile
// rules into queues. The monitor compares DUT activity against those
// queues on the falling edge.
module tb_corelet_ctrl;
  localparam int BW       = 4;
  localparam int PSUM_BW  = 16;
  localparam int COL      = 8;
  localparam int ROW      = 8;
  localparam int NUM_X    = 16;
  localparam int ADDR_BW  = 11;
  localparam int SETTLE   = ROW + COL;
  localparam int TILE_LEN = (COL + 1) + COL + SETTLE + (NUM_X + 1) + NUM_X + (NUM_X + 1) + 1;

  logic clk = 1'b0;
  logic reset, start;
  logic [ADDR_BW-1:0] w_base, x_base, o_base;
  logic busy, done, xmem_cen;
  logic [ADDR_BW-1:0] xmem_addr;
  logic [BW*ROW-1:0] xmem_q;
  logic l0_wr, l0_rd;
  logic [BW*ROW-1:0] l0_wdata;
  logic ififo_wr, ififo_rd;
  logic [BW*ROW-1:0] ififo_wdata;
  logic [2:0] inst_w;
  logic ofifo_rd, ofifo_valid;
  logic [PSUM_BW*COL-1:0] ofifo_rdata;
  logic pmem_cen, pmem_wen;
  logic [ADDR_BW-1:0] pmem_addr;
  logic [PSUM_BW*COL-1:0] pmem_d;
  logic [2:0] state_dbg;
`ifdef CORELET_CTRL_PERF_EN
  logic [31:0] perf_cycles;
  logic [15:0] perf_stall;
`endif

  corelet_ctrl dut (
    .clk(clk), .reset(reset), .start(start),
    .w_base(w_base), .x_base(x_base), .o_base(o_base),
    .busy(busy), .done(done),
    .xmem_cen(xmem_cen), .xmem_addr(xmem_addr), .xmem_q(xmem_q),
    .l0_wr(l0_wr), .l0_rd(l0_rd), .l0_wdata(l0_wdata),
    .ififo_wr(ififo_wr), .ififo_rd(ififo_rd), .ififo_wdata(ififo_wdata),
    .inst_w(inst_w),
    .ofifo_rd(ofifo_rd), .ofifo_valid(ofifo_valid), .ofifo_rdata(ofifo_rdata),
    .pmem_cen(pmem_cen), .pmem_wen(pmem_wen), .pmem_addr(pmem_addr), .pmem_d(pmem_d),
    .state_dbg(state_dbg)
`ifdef CORELET_CTRL_PERF_EN
    , .perf_cycles(perf_cycles), .perf_stall(perf_stall)
`endif
  );

  // ---------------- clock / cycle count ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- memory models ----------------
  logic [BW*ROW-1:0] xmem [0:(1<<ADDR_BW)-1];
  always @(posedge clk) if (!xmem_cen) xmem_q <= xmem[xmem_addr];

  logic [PSUM_BW*COL-1:0] orow [0:63];
  int rd_idx = 0;
  logic ofifo_en;
  assign ofifo_valid = ofifo_en;
  assign ofifo_rdata = orow[rd_idx % 64];
  always @(posedge clk) if (ofifo_rd && ofifo_valid) rd_idx <= rd_idx + 1;

  // ---------------- scoreboard ----------------
  logic [ADDR_BW-1:0]     exp_xaddr_q[$];
  logic [BW*ROW-1:0]      exp_l0_q[$];
  logic [ADDR_BW-1:0]     exp_paddr_q[$];
  logic [PSUM_BW*COL-1:0] exp_pd_q[$];

  int n_vec = 0, n_err = 0;
  int n_kload, n_exec, n_bad_inst, n_rd, n_bad_rd, n_wr, n_bad_wr, n_done, n_extra, done_cyc;
  int tile_start;
  bit first_pending, saw_wrap, prev_rd;
  logic [ADDR_BW-1:0] last_xaddr;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (xmem_cen === 1'b0) begin
      if (first_pending) begin
        chk("first_read_cycle", 128'(cyc), 128'(tile_start));
        first_pending = 1'b0;
      end
      if (exp_xaddr_q.size() != 0) chk("xmem_addr", 128'(xmem_addr), 128'(exp_xaddr_q.pop_front()));
      else n_extra++;
      if (last_xaddr == 11'd2047 && xmem_addr == 11'd0) saw_wrap = 1'b1;
      last_xaddr = xmem_addr;
    end
    if (l0_wr) begin
      if (exp_l0_q.size() != 0) chk("l0_wdata", 128'(l0_wdata), 128'(exp_l0_q.pop_front()));
      else n_extra++;
    end
    if (inst_w == 3'b001) n_kload++;
    else if (inst_w == 3'b010) begin
      n_exec++;
      if (n_kload != COL) n_bad_inst++;
    end else if (inst_w != 3'b000) n_bad_inst++;
    if (ofifo_rd) begin
      n_rd++;
      if (!ofifo_valid) n_bad_rd++;
    end
    if (prev_rd != (!pmem_cen && !pmem_wen)) n_bad_wr++;
    if (!pmem_cen && !pmem_wen) begin
      n_wr++;
      if (exp_paddr_q.size() != 0) begin
        chk("pmem_addr", 128'(pmem_addr), 128'(exp_paddr_q.pop_front()));
        chk("pmem_d", 128'(pmem_d), 128'(exp_pd_q.pop_front()));
      end else n_extra++;
    end
    prev_rd = ofifo_rd;
    if (done) begin
      n_done++;
      done_cyc = cyc;
      chk("busy_low_at_done", 128'(busy), 128'(0));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check_idle(input string tag);
    chk({tag, "_ctrl"}, 128'({busy, done, xmem_cen, pmem_cen, pmem_wen, l0_wr, l0_rd,
                             ififo_wr, ififo_rd, ofifo_rd, inst_w}), 128'(13'b0011100000000));
    chk({tag, "_addr"}, 128'({xmem_addr, pmem_addr}), 128'(0));
    chk({tag, "_l0data"}, 128'({l0_wdata, ififo_wdata}), 128'(0));
    chk({tag, "_pmem_d"}, 128'(pmem_d), 128'(0));
  endtask

  task automatic begin_tile(input logic [ADDR_BW-1:0] w, x, o);
    logic [ADDR_BW-1:0] a;
    exp_xaddr_q.delete(); exp_l0_q.delete(); exp_paddr_q.delete(); exp_pd_q.delete();
    for (int i = 0; i < COL; i++) begin
      a = w + ADDR_BW'(i);
      exp_xaddr_q.push_back(a); exp_l0_q.push_back(xmem[a]);
    end
    for (int i = 0; i < NUM_X; i++) begin
      a = x + ADDR_BW'(i);
      exp_xaddr_q.push_back(a); exp_l0_q.push_back(xmem[a]);
    end
    for (int k = 0; k < NUM_X; k++) begin
      exp_paddr_q.push_back(o + ADDR_BW'(k));
      exp_pd_q.push_back(orow[(rd_idx + k) % 64]);
    end
    n_kload = 0; n_exec = 0; n_bad_inst = 0; n_rd = 0; n_bad_rd = 0; n_wr = 0;
    n_bad_wr = 0; n_done = 0; n_extra = 0; done_cyc = -1;
    saw_wrap = 1'b0; last_xaddr = '0; first_pending = 1'b1;
    @(posedge clk); #1;
    start = 1'b1; w_base = w; x_base = x; o_base = o;
    @(posedge clk); #1;
    start = 1'b0;
    tile_start = cyc;
    chk("busy_after_start", 128'(busy), 128'(1));
  endtask

  task automatic run_tile(input logic [ADDR_BW-1:0] w, x, o, input int gap,
                          input int stall_after, input bit mid_start);
    int g;
    bit in_gap, gap_started, ms_sent, ms_clear;
    g = 0; in_gap = 0; gap_started = 0; ms_sent = 0; ms_clear = 0;
    begin_tile(w, x, o);
    for (int c = 0; c < 400 && n_done == 0; c++) begin
      @(posedge clk); #1;
      if (ms_clear) begin start = 1'b0; ms_clear = 0; end
      if (mid_start && !ms_sent && n_exec >= 3) begin
        start = 1'b1;
        w_base = 11'($urandom_range(0, 2047));
        x_base = 11'($urandom_range(0, 2047));
        o_base = 11'($urandom_range(0, 2047));
        ms_sent = 1; ms_clear = 1;
      end
      if (in_gap) begin
        g++;
        if (g == gap) begin ofifo_en = 1'b1; in_gap = 0; end
      end else if (gap > 0 && !gap_started && n_rd >= stall_after) begin
        ofifo_en = 1'b0; in_gap = 1; gap_started = 1;
      end
    end
    ofifo_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("done_count", 128'(n_done), 128'(1));
    chk("done_cycle", 128'(done_cyc), 128'(tile_start + TILE_LEN - 1 + gap));
    chk("kload_cycles", 128'(n_kload), 128'(COL));
    chk("exec_cycles", 128'(n_exec), 128'(NUM_X));
    chk("inst_order", 128'(n_bad_inst), 128'(0));
    chk("ofifo_reads", 128'(n_rd), 128'(NUM_X));
    chk("read_while_invalid", 128'(n_bad_rd), 128'(0));
    chk("psum_writes", 128'(n_wr), 128'(NUM_X));
    chk("write_trails_read", 128'(n_bad_wr), 128'(0));
    chk("extra_events", 128'(n_extra), 128'(0));
    chk("left_expected", 128'(exp_xaddr_q.size() + exp_l0_q.size() + exp_paddr_q.size()), 128'(0));
    chk("busy_after_done", 128'(busy), 128'(0));
`ifdef CORELET_CTRL_PERF_EN
    chk("perf_cycles", 128'(perf_cycles), 128'(TILE_LEN + gap));
    chk("perf_stall", 128'(perf_stall), 128'(gap));
`endif
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    reset = 1'b1; start = 1'b0; w_base = '0; x_base = '0; o_base = '0; ofifo_en = 1'b1;
    first_pending = 1'b0; prev_rd = 1'b0; tile_start = 0;
    n_kload = 0; n_exec = 0; n_bad_inst = 0; n_rd = 0; n_bad_rd = 0; n_wr = 0;
    n_bad_wr = 0; n_done = 0; n_extra = 0; done_cyc = -1;
    for (int i = 0; i < (1 << ADDR_BW); i++) xmem[i] = 32'($urandom);
    for (int i = 0; i < 64; i++) orow[i] = {$urandom, $urandom, $urandom, $urandom};

    // Reset, then idle: outputs stay at reset values.
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check_idle("post_reset");
    end

    // Baseline tile, no stalls.
    run_tile(11'd0, 11'd8, 11'd100, 0, 0, 1'b0);
    // Ten-cycle OFIFO gap in the middle of the drain.
    run_tile(11'($urandom_range(0, 2047)), 11'($urandom_range(0, 2047)),
             11'($urandom_range(0, 2047)), 10, 5, 1'b0);
    // Stray start during EXEC must be ignored.
    run_tile(11'd300, 11'd400, 11'd500, 0, 0, 1'b1);

    // Abort during the activation fetch, then restart across the address wrap.
    begin_tile(11'd20, 11'd40, 11'd60);
    for (int c = 0; c < 100 && exp_xaddr_q.size() > NUM_X - 3; c++) begin
      @(posedge clk); #1;
    end
    chk("reached_xfetch", 128'(exp_xaddr_q.size() <= NUM_X - 3), 128'(1));
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check_idle("abort_reset");
    chk("abort_no_psum_write", 128'(n_wr), 128'(0));
    exp_xaddr_q.delete(); exp_l0_q.delete(); exp_paddr_q.delete(); exp_pd_q.delete();
    first_pending = 1'b0;
    repeat (2) @(posedge clk);
    #1 check_idle("abort_idle");
    run_tile(11'd100, 11'd2040, 11'd700, 0, 0, 1'b0);
    chk("xaddr_wrap", 128'(saw_wrap), 128'(1));

    // Random tiles with random drain gaps.
    for (int t = 0; t < 4; t++) begin
      run_tile(11'($urandom_range(0, 2047)), 11'($urandom_range(0, 2047)),
               11'($urandom_range(0, 2047)), int'($urandom_range(0, 12)),
               int'($urandom_range(1, 15)), 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
